mxu_scheduler: RTL



---
 rtl/mxu_scheduler.sv | 105 ++++++++++
 1 files changed

// File: rtl/mxu_scheduler.sv
// mxu_scheduler: round-robin sharing of one DIM x DIM matrix multiplier among NUM_REQ requesters
//   req_valid/req_ready/req_a/req_b : per-requester handshake, slice i of req_a/req_b belongs to requester i
//   rsp_valid/rsp_ready/rsp_id/rsp_y/rsp_err : tagged result, rsp_err marks a watchdog abort (rsp_y = 0)
//   mxu_start/mxu_in0/mxu_in1/mxu_out/mxu_finished : multiplier interface
//   busy/timeout_flag/done_count : status (timeout_flag is sticky until reset)
module mxu_scheduler #(
    parameter int DIM = 4,
    parameter int WIDTH = 16,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024,
    localparam int MW = DIM * DIM * WIDTH,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*MW-1:0] req_a,
    input  logic [NUM_REQ*MW-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IW-1:0]         rsp_id,
    output logic [MW-1:0]         rsp_y,
    output logic                  rsp_err,
    output logic                  mxu_start,
    output logic [MW-1:0]         mxu_in0,
    output logic [MW-1:0]         mxu_in1,
    input  logic [MW-1:0]         mxu_out,
    input  logic                  mxu_finished,
    output logic                  busy,
    output logic                  timeout_flag,
    output logic [15:0]           done_count
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_n;
    logic [IW-1:0] last_grant, grant, id, idx;
    logic [MW-1:0] op_a, op_b, sel_a, sel_b;
    logic [31:0] wd;
    logic any, hit_to, done;
    // Scanning downward lets the candidate closest after last_grant overwrite the others.
    always_comb begin
        grant = last_grant;
        idx = last_grant;
        sel_a = '0;
        sel_b = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((int'(last_grant) + k) % NUM_REQ);
            if (req_valid[idx]) grant = idx;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == grant) begin
                sel_a = req_a[i*MW +: MW];
                sel_b = req_b[i*MW +: MW];
            end
        end
    end
    always_comb begin
        any = |req_valid;
        hit_to = (TIMEOUT != 0) && (wd == 32'(TIMEOUT - 1));
        done = mxu_finished || hit_to;
        state_n = state == IDLE  ? (any ? ISSUE : IDLE) :
                  state == ISSUE ? WAIT :
                  state == WAIT  ? (done ? RESP : WAIT) :
                  (rsp_ready ? IDLE : RESP);
        req_ready = (state == IDLE && any) ? NUM_REQ'(1) << grant : '0;
        mxu_start = state == ISSUE;
        rsp_valid = state == RESP;
        busy = state != IDLE;
    end
    assign rsp_id = id;
    assign mxu_in0 = op_a;
    assign mxu_in1 = op_b;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last_grant <= IW'(NUM_REQ - 1);
            id <= '0;
            op_a <= '0;
            op_b <= '0;
            wd <= '0;
            rsp_y <= '0;
            rsp_err <= 1'b0;
            timeout_flag <= 1'b0;
            done_count <= '0;
        end else begin
            state <= state_n;
            wd <= state == WAIT ? wd + 32'd1 : '0;
            if (state == IDLE && any) begin
                id <= grant;
                op_a <= sel_a;
                op_b <= sel_b;
            end
            // A finish on the threshold cycle still counts as a normal completion.
            if (state == WAIT && done) begin
                rsp_y <= mxu_finished ? mxu_out : '0;
                rsp_err <= !mxu_finished;
                timeout_flag <= timeout_flag | !mxu_finished;
            end
            if (state == RESP && rsp_ready) begin
                last_grant <= id;
                done_count <= done_count + 16'd1;
            end
        end
    end
endmodule
